// File: rtl/tag_match_resolver_if.sv
`timescale 1ns/1ps
// Output beat stream of the tag match resolver: one matched row per beat.
// Master drives valid/data/addr/last, slave returns ready.
// A beat is held stable until ready is seen with valid.
interface tag_match_resolver_if #(
    parameter int WORD_SIZE = 8,
    parameter int ADDR_W    = 7
);
    logic                 out_valid;
    logic                 out_ready;
    logic [WORD_SIZE-1:0] out_data;
    logic [ADDR_W-1:0]    out_addr;
    logic                 out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_addr,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_addr,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/tag_match_resolver.sv
`timescale 1ns/1ps
// Walks a captured CAM match vector and emits each matched row (address + CAM word) in ascending order.
// Latency: first beat valid two edges after start is driven; beats spaced two cycles apart at full rate.
// Backpressure: a beat is held until out_ready; abort cancels immediately and wins over out_ready.
module tag_match_resolver #(
    parameter int CELL_QUANT = 128,
    parameter int WORD_SIZE  = 8,
    parameter int ADDR_W     = 7
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [CELL_QUANT-1:0] tags_in,
    input  logic [WORD_SIZE-1:0]  cam_doutb,
    output logic [ADDR_W-1:0]     rd_addr,
    tag_match_resolver_if.master  out_if,
    output logic [ADDR_W:0]       match_count,
    output logic                  any_match,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        OUT  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                state_q;
    state_t                state_nxt;
    logic [CELL_QUANT-1:0] pending;
    logic [CELL_QUANT-1:0] pending_clr;
    logic [ADDR_W:0]       tag_count;
    logic [ADDR_W-1:0]     low_idx;
    logic                  valid_q;
    logic [WORD_SIZE-1:0]  data_q;
    logic [ADDR_W-1:0]     addr_q;
    logic                  last_q;

    // Population count of the incoming vector; ADDR_W+1 bits so an all-ones vector fits.
    always_comb begin
        tag_count = '0;
        for (int i = 0; i < CELL_QUANT; i++) begin
            tag_count = tag_count + {{ADDR_W{1'b0}}, tags_in[i]};
        end
    end

    // Priority encoder: lowest set index of pending, scanned downward so the lowest wins.
    always_comb begin
        low_idx = '0;
        for (int i = CELL_QUANT - 1; i >= 0; i--) begin
            if (pending[i]) begin
                low_idx = ADDR_W'(i);
            end
        end
    end

    // x & (x-1) drops exactly the lowest set bit, i.e. the row currently addressed.
    assign pending_clr = pending & (pending - {{(CELL_QUANT-1){1'b0}}, 1'b1});

    assign rd_addr          = low_idx;
    assign any_match        = (match_count != '0);
    assign busy             = (state_q != IDLE);
    assign done             = (state_q == DONE);
    assign out_if.out_valid = valid_q;
    assign out_if.out_data  = data_q;
    assign out_if.out_addr  = addr_q;
    assign out_if.out_last  = last_q;

    // State register.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic; abort is only honoured while a scan or beat is in flight.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_nxt = (tags_in != '0) ? SCAN : DONE;
                end
            end
            SCAN: begin
                state_nxt = abort ? DONE : OUT;
            end
            OUT: begin
                if (abort) begin
                    state_nxt = DONE;
                end else if (out_if.out_ready) begin
                    state_nxt = (pending == '0) ? DONE : SCAN;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Capture, beat registers and pending-vector bookkeeping.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            pending     <= '0;
            match_count <= '0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            addr_q      <= '0;
            last_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        pending     <= tags_in;
                        match_count <= tag_count;
                    end
                end
                SCAN: begin
                    if (abort) begin
                        pending <= '0;
                        valid_q <= 1'b0;
                    end else begin
                        data_q  <= cam_doutb;
                        addr_q  <= low_idx;
                        last_q  <= (pending_clr == '0);
                        valid_q <= 1'b1;
                        pending <= pending_clr;
                    end
                end
                OUT: begin
                    if (abort) begin
                        pending <= '0;
                        valid_q <= 1'b0;
                    end else if (out_if.out_ready) begin
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tag_match_resolver.sv
`timescale 1ns/1ps
// Directed bench for tag_match_resolver: CAM modelled as row index XOR a per-test mask.
// Inputs change 1ns after the rising edge, outputs are checked at the same point.
// Backpressure, abort and mid-scan reset are exercised with cycle-exact expectations.
module tb_tag_match_resolver;

    localparam int CQ = 128;
    localparam int WS = 8;
    localparam int AW = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [CQ-1:0] tags;
    logic [WS-1:0] cam_doutb;
    logic [WS-1:0] cam_xor;
    logic [AW-1:0] rd_addr;
    logic [AW:0]   match_count;
    logic          any_match;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    tag_match_resolver_if #(.WORD_SIZE(WS), .ADDR_W(AW)) oif ();

    tag_match_resolver #(.CELL_QUANT(CQ), .WORD_SIZE(WS), .ADDR_W(AW)) dut (
        .clock       (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .tags_in     (tags),
        .cam_doutb   (cam_doutb),
        .rd_addr     (rd_addr),
        .out_if      (oif.master),
        .match_count (match_count),
        .any_match   (any_match),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // CAM model: word stored at row r is r ^ cam_xor.
    assign cam_doutb = {1'b0, rd_addr} ^ cam_xor;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input int row, input logic last);
        chk({tag, " valid"}, 32'(oif.out_valid), 32'd1);
        chk({tag, " addr"},  32'(oif.out_addr),  32'(row));
        chk({tag, " data"},  32'(oif.out_data),  32'(row[7:0] ^ cam_xor));
        chk({tag, " last"},  32'(oif.out_last),  32'(last));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " valid"}, 32'(oif.out_valid), 32'd0);
        chk({tag, " data"},  32'(oif.out_data),  32'd0);
        chk({tag, " addr"},  32'(oif.out_addr),  32'd0);
        chk({tag, " last"},  32'(oif.out_last),  32'd0);
        chk({tag, " count"}, 32'(match_count),   32'd0);
        chk({tag, " any"},   32'(any_match),     32'd0);
        chk({tag, " busy"},  32'(busy),          32'd0);
        chk({tag, " done"},  32'(done),          32'd0);
        chk({tag, " rdaddr"}, 32'(rd_addr),      32'd0);
    endtask

    int rows3 [3] = '{3, 10, 127};

    initial begin
        rst = 1'b0; start = 1'b0; abort = 1'b0; tags = '0;
        oif.out_ready = 1'b0; cam_xor = '0;

        // Reset state
        #3;
        chk_reset("rst");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // Empty vector: straight to DONE, no beats
        tags = '0; start = 1'b1;
        tick(); start = 1'b0;
        chk("empty done", 32'(done), 32'd1);
        chk("empty busy", 32'(busy), 32'd1);
        chk("empty count", 32'(match_count), 32'd0);
        chk("empty any", 32'(any_match), 32'd0);
        chk("empty valid", 32'(oif.out_valid), 32'd0);
        tick();
        chk("empty done2", 32'(done), 32'd0);
        chk("empty idle", 32'(busy), 32'd0);
        chk("empty valid2", 32'(oif.out_valid), 32'd0);

        // Rows 3,10,127 at full rate; tags_in changes after capture
        tags = '0; tags[3] = 1'b1; tags[10] = 1'b1; tags[127] = 1'b1;
        oif.out_ready = 1'b1; start = 1'b1;
        tick(); start = 1'b0; tags = '1;
        chk("three busy", 32'(busy), 32'd1);
        chk("three count", 32'(match_count), 32'd3);
        chk("three any", 32'(any_match), 32'd1);
        chk("three scanvalid", 32'(oif.out_valid), 32'd0);
        chk("three rdaddr", 32'(rd_addr), 32'd3);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_beat("three beat", rows3[k], k == 2);
            tick();
            chk("three gap", 32'(oif.out_valid), 32'd0);
            if (k < 2) chk("three nodone", 32'(done), 32'd0);
        end
        chk("three done", 32'(done), 32'd1);
        tick();
        chk("three idle", 32'(busy), 32'd0);
        chk("three hold", 32'(match_count), 32'd3);

        // Single row 5 under backpressure; start during OUT is ignored
        tags = '0; tags[5] = 1'b1; oif.out_ready = 1'b0; cam_xor = 8'h3C; start = 1'b1;
        tick(); start = 1'b0;
        tick();
        for (int j = 0; j < 4; j++) begin
            chk_beat("stall beat", 5, 1'b1);
            if (j == 1) begin start = 1'b1; tags = '1; end
            if (j == 2) start = 1'b0;
            tick();
        end
        chk_beat("stall beat", 5, 1'b1);
        chk("stall count", 32'(match_count), 32'd1);
        oif.out_ready = 1'b1;
        tick();
        chk("stall done", 32'(done), 32'd1);
        chk("stall valid", 32'(oif.out_valid), 32'd0);
        tick();
        chk("stall idle", 32'(busy), 32'd0);
        chk("stall done2", 32'(done), 32'd0);

        // All 128 rows, full count without overflow
        tags = '1; cam_xor = 8'h5A; start = 1'b1;
        tick(); start = 1'b0;
        chk("all count", 32'(match_count), 32'd128);
        chk("all any", 32'(any_match), 32'd1);
        for (int i = 0; i < CQ; i++) begin
            tick();
            chk_beat("all beat", i, i == CQ - 1);
            tick();
            chk("all gap", 32'(oif.out_valid), 32'd0);
        end
        chk("all done", 32'(done), 32'd1);
        tick();
        chk("all idle", 32'(busy), 32'd0);
        chk("all hold", 32'(match_count), 32'd128);

        // Abort during first beat together with out_ready
        tags = '0; tags[1] = 1'b1; tags[2] = 1'b1; cam_xor = 8'hC3; start = 1'b1;
        tick(); start = 1'b0;
        tick();
        chk_beat("abort beat", 1, 1'b0);
        abort = 1'b1;
        tick(); abort = 1'b0;
        chk("abort valid", 32'(oif.out_valid), 32'd0);
        chk("abort done", 32'(done), 32'd1);
        chk("abort count", 32'(match_count), 32'd2);
        tick();
        chk("abort idle", 32'(busy), 32'd0);
        chk("abort done2", 32'(done), 32'd0);
        chk("abort valid2", 32'(oif.out_valid), 32'd0);
        chk("abort rdaddr", 32'(rd_addr), 32'd0);
        tick();
        chk("abort nobeat", 32'(oif.out_valid), 32'd0);
        abort = 1'b1;
        tick(); abort = 1'b0;
        chk("abort idle noeffect", 32'(busy), 32'd0);
        chk("abort idle nodone", 32'(done), 32'd0);

        // Reset asserted during SCAN, then a clean resolution
        tags = '0; tags[4] = 1'b1; tags[9] = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        chk("mid busy", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk_reset("mid rst");
        tick();
        chk("mid rst held", 32'(busy), 32'd0);
        rst = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        chk("post count", 32'(match_count), 32'd2);
        tick();
        chk_beat("post beat", 4, 1'b0);
        tick();
        tick();
        chk_beat("post beat", 9, 1'b1);
        tick();
        chk("post done", 32'(done), 32'd1);
        tick();
        chk("post idle", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
